// File: rtl/silife_pkg.sv
// silife_pkg: shared types and constants for the silife Wishbone initiator.
//   wbi_state_t  - initiator FSM states
//   wb_cmd_t     - command word {we, addr, data}, 65 bits
//   GRID_BASE / REG_* - silife grid window base and register byte offsets
package silife_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        GAP
    } wbi_state_t;

    localparam logic [31:0] GRID_BASE              = 32'h0000_1000;
    localparam logic [31:0] REG_CTRL               = 32'h0000_0000;
    localparam logic [31:0] REG_CONFIG             = 32'h0000_0004;
    localparam logic [31:0] REG_MAX7219_CTRL       = 32'h0000_0010;
    localparam logic [31:0] REG_MAX7219_CONFIG     = 32'h0000_0014;
    localparam logic [31:0] REG_MAX7219_BRIGHTNESS = 32'h0000_0018;
    localparam logic [31:0] REG_DBG_LOCAL_ADDRESS  = 32'h0000_0020;

    localparam int CMD_W = 65;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } wb_cmd_t;

    // Byte address of grid row 'row' in a window starting at 'base'.
    function automatic logic [31:0] grid_row_addr(input logic [31:0] base, input int unsigned row);
        return base + 32'(row * 4);
    endfunction

endpackage

// File: rtl/silife_cmd_fifo.sv
// silife_cmd_fifo: synchronous FIFO holding pending initiator commands.
//   clk, reset   - clock, synchronous active-high reset (empties the FIFO)
//   i_push       - write i_data (ignored when full)
//   i_pop        - drop the head entry (ignored when empty)
//   o_head       - current head entry, valid while !o_empty
//   o_full, o_empty - occupancy flags from registered pointers
module silife_cmd_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_head  = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/silife_wb_initiator.sv
// silife_wb_initiator: Wishbone classic initiator for the silife slave.
// Commands {we, addr, data} arrive on a valid/ready port into a FIFO; each one
// runs a single-beat bus cycle and yields exactly one in-order response.
//   clk, reset        - clock, synchronous active-high reset
//   i_cmd_*/o_cmd_ready - command push port (ready = FIFO not full)
//   o_rsp_*/i_rsp_ready - response slot, held until accepted; err = timeout
//   o_wb_*/i_wb_*     - Wishbone classic initiator port (stb == cyc)
//   o_busy            - commands pending, bus cycle in progress or response held
module silife_wb_initiator
    import silife_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] GRID_BASE  = silife_pkg::GRID_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [31:0] i_cmd_addr,
    input  logic [31:0] i_cmd_data,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    output logic        o_busy
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    wb_cmd_t    push_cmd, head_cmd;
    logic       fifo_full, fifo_empty, push, pop;

    wbi_state_t       state_q, state_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    assign push_cmd    = '{we: i_cmd_we, addr: i_cmd_addr, data: i_cmd_data};
    assign o_cmd_ready = !fifo_full;
    assign push        = i_cmd_valid && !fifo_full;

    silife_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (push),
        .i_data  (push_cmd),
        .i_pop   (pop),
        .o_head  (head_cmd),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q && !i_rsp_ready;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                // Only start when the response slot is free by the time this
                // command could possibly finish.
                if (!fifo_empty && (!rsp_valid_q || i_rsp_ready)) begin
                    pop     = 1'b1;
                    we_d    = head_cmd.we;
                    addr_d  = head_cmd.addr;
                    wdata_d = head_cmd.data;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (i_wb_ack) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = we_q ? 32'h0 : i_wb_data;
                    state_d     = GAP;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = 32'h0;
                    state_d     = GAP;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // The slave's registered ack lands here once more; skip it.
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = cyc_q;
    assign o_wb_we     = we_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_data   = wdata_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_busy      = !fifo_empty || (state_q != IDLE) || rsp_valid_q;

endmodule

// File: tb/tb_silife_wb_initiator.sv
// Directed bench for silife_wb_initiator with a behavioural silife-like slave.
// Slave modes: 0 = registered ack (one cycle late, trailing duplicate ack),
// 1 = immediate combinational ack, 2 = never acks.
module tb_silife_wb_initiator;
    import silife_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_data = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [31:0] rsp_data;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, busy;
    logic [31:0] wb_addr, wb_wdata, wb_rdata;

    int checks = 0;
    int errors = 0;

    silife_wb_initiator #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (16),
        .GRID_BASE  (GRID_BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_we    (cmd_we),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_data  (cmd_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
        .o_wb_we     (wb_we),
        .o_wb_addr   (wb_addr),
        .o_wb_data   (wb_wdata),
        .i_wb_ack    (wb_ack),
        .i_wb_data   (wb_rdata),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    logic [1:0]  slv_mode = 2'd0;
    logic        ack_r;
    logic [31:0] ctrl_r, bright_r;
    logic [31:0] grid_r [0:7];

    assign wb_ack = (slv_mode == 2'd1) ? (wb_cyc && wb_stb) :
                    (slv_mode == 2'd0) ? ack_r : 1'b0;

    always_comb begin
        wb_rdata = 32'hDEAD_BEEF;
        if (wb_addr == REG_CTRL) wb_rdata = ctrl_r;
        else if (wb_addr == REG_MAX7219_BRIGHTNESS) wb_rdata = bright_r;
        else if (wb_addr >= GRID_BASE && wb_addr < GRID_BASE + 32'd32) wb_rdata = grid_r[wb_addr[4:2]];
    end

    always @(posedge clk) begin
        if (reset) begin
            ack_r    <= 1'b0;
            ctrl_r   <= 32'h0;
            bright_r <= 32'h0000_000F;
            for (int i = 0; i < 8; i++) grid_r[i] <= 32'h0;
        end else begin
            ack_r <= (slv_mode == 2'd0) && wb_cyc && wb_stb;
            if (wb_ack && wb_cyc && wb_stb && wb_we) begin
                if (wb_addr == REG_CTRL) ctrl_r <= wb_wdata;
                else if (wb_addr == REG_MAX7219_BRIGHTNESS) bright_r <= wb_wdata;
                else if (wb_addr >= GRID_BASE && wb_addr < GRID_BASE + 32'd32) grid_r[wb_addr[4:2]] <= wb_wdata;
            end
        end
    end

    // ---------------- monitors ----------------
    logic [32:0] rsp_q [$];
    int          rise_q [$];
    int          cyc_cnt = 0;
    logic        stb_prev = 1'b0;

    always @(posedge clk) begin
        cyc_cnt  <= cyc_cnt + 1;
        stb_prev <= wb_stb;
        if (wb_stb && !stb_prev) rise_q.push_back(cyc_cnt);
        if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_err, rsp_data});
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] data);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_data  = data;
        for (int i = 0; i < 100 && !cmd_ready; i++) tick();
        chk("push_ready", {31'h0, cmd_ready}, 32'h1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && rsp_q.size() < n; i++) tick();
        chk(tag, 32'(rsp_q.size()), 32'(n));
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] w5_data [0:5];
    int          w5_row  [0:5];
    int          nstb;

    initial begin
        w5_data = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
        w5_row  = '{0, 1, 0, 2, 3, 0};

        // 1. Reset
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_cyc", {31'h0, wb_cyc}, 32'h0);
        chk("rst_stb", {31'h0, wb_stb}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        // Reset in the middle of a bus cycle
        slv_mode = 2'd2;
        push(1'b0, REG_MAX7219_BRIGHTNESS, 32'h0);
        tick();
        chk("midrst_stb_up", {31'h0, wb_stb}, 32'h1);
        reset = 1'b1;
        tick();
        chk("midrst_stb_drop", {31'h0, wb_stb}, 32'h0);
        reset = 1'b0;
        repeat (3) tick();
        chk("midrst_no_rsp", 32'(rsp_q.size()), 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);

        // 2. Write CTRL = 1, registered-ack slave
        slv_mode = 2'd0;
        rsp_q.delete();
        push(1'b1, REG_CTRL, 32'h1);
        chk("t2_stb_pre", {31'h0, wb_stb}, 32'h0);
        tick();
        chk("t2_stb_e1", {31'h0, wb_stb}, 32'h1);
        chk("t2_we", {31'h0, wb_we}, 32'h1);
        chk("t2_addr", wb_addr, REG_CTRL);
        chk("t2_wdata", wb_wdata, 32'h1);
        tick();
        chk("t2_stb_held", {31'h0, wb_stb}, 32'h1);
        chk("t2_rsp_not_yet", {31'h0, rsp_valid}, 32'h0);
        tick();
        chk("t2_stb_drop", {31'h0, wb_stb}, 32'h0);
        chk("t2_rsp_valid_e3", {31'h0, rsp_valid}, 32'h1);
        chk("t2_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("t2_rsp_data", rsp_data, 32'h0);
        chk("t2_gap_busy", {31'h0, busy}, 32'h1);
        tick();
        chk("t2_rsp_consumed", {31'h0, rsp_valid}, 32'h0);
        chk("t2_enable", ctrl_r, 32'h1);
        repeat (3) tick();
        chk("t2_one_rsp", 32'(rsp_q.size()), 32'h1);

        // 3. Read MAX7219_BRIGHTNESS, slave acks twice
        rsp_q.delete();
        push(1'b0, REG_MAX7219_BRIGHTNESS, 32'h0);
        wait_rsp("t3_rsp_wait", 1, 20);
        chk("t3_data", rsp_q[0][31:0], 32'h0000_000F);
        chk("t3_err", {31'h0, rsp_q[0][32]}, 32'h0);
        repeat (6) tick();
        chk("t3_single_rsp", 32'(rsp_q.size()), 32'h1);

        // 4. Timeout: slave never acks
        slv_mode = 2'd2;
        rsp_q.delete();
        push(1'b0, 32'h0000_2000, 32'h0);
        nstb = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wb_stb) nstb++;
        end
        chk("t4_stb_cycles", 32'(nstb), 32'd16);
        chk("t4_rsp_count", 32'(rsp_q.size()), 32'h1);
        chk("t4_err", {31'h0, rsp_q[0][32]}, 32'h1);
        chk("t4_data", rsp_q[0][31:0], 32'h0);
        slv_mode = 2'd0;
        push(1'b1, grid_row_addr(GRID_BASE, 1), 32'h0000_0055);
        wait_rsp("t4_next_wait", 2, 20);
        chk("t4_next_err", {31'h0, rsp_q[1][32]}, 32'h0);
        chk("t4_next_write", grid_r[1], 32'h0000_0055);

        // 5. Backpressure and ordering
        rsp_q.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(1'b1, grid_row_addr(GRID_BASE, w5_row[i]), w5_data[i]);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = grid_row_addr(GRID_BASE, w5_row[5]);
        cmd_data  = w5_data[5];
        chk("t5_full_ready", {31'h0, cmd_ready}, 32'h0);
        chk("t5_first_done", {31'h0, rsp_valid}, 32'h1);
        repeat (3) tick();
        chk("t5_still_full", {31'h0, cmd_ready}, 32'h0);
        chk("t5_none_taken", 32'(rsp_q.size()), 32'h0);
        rsp_ready = 1'b1;
        chk("t5_ready_pop_cycle", {31'h0, cmd_ready}, 32'h0);
        tick();
        chk("t5_ready_after_pop", {31'h0, cmd_ready}, 32'h1);
        push(1'b1, grid_row_addr(GRID_BASE, w5_row[5]), w5_data[5]);
        push(1'b0, grid_row_addr(GRID_BASE, 0), 32'h0);
        wait_rsp("t5_rsp_wait", 7, 200);
        for (int i = 0; i < 6; i++) chk($sformatf("t5_wr%0d_rsp", i), rsp_q[i][31:0] | {31'h0, rsp_q[i][32]}, 32'h0);
        chk("t5_rd_row0", rsp_q[6][31:0], 32'h0000_0066);
        chk("t5_rd_err", {31'h0, rsp_q[6][32]}, 32'h0);

        // 6. Streaming with rsp_ready held, immediate-ack slave
        slv_mode = 2'd1;
        repeat (4) tick();
        rsp_q.delete();
        rise_q.delete();
        for (int k = 0; k < 4; k++) push(1'b1, grid_row_addr(GRID_BASE, 4 + k), 32'h100 + 32'(k));
        for (int k = 0; k < 4; k++) push(1'b0, grid_row_addr(GRID_BASE, 4 + k), 32'h0);
        wait_rsp("t6_rsp_wait", 8, 100);
        repeat (5) tick();
        chk("t6_rsp_count", 32'(rsp_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < rsp_q.size(); k++)
            chk($sformatf("t6_rsp%0d", k), rsp_q[k][31:0], (k < 4) ? 32'h0 : 32'h100 + 32'(k - 4));
        chk("t6_rise_count", 32'(rise_q.size()), 32'd8);
        for (int k = 1; k < 8 && k < rise_q.size(); k++)
            chk($sformatf("t6_gap%0d", k), 32'(rise_q[k] - rise_q[k-1]), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
